alu_issuer: RTL and testbench

Command-side front end for the N-bit signed ALU. It accepts add/sub/compare commands over a valid/ready stream and buffers them in a small FIFO. It issues each command to the ALU as a one-cycle `ena` pulse, captures the registered 9-bit result one cycle later, and returns it in order over a valid/ready response stream. It sits between the command source and the ALU and owns the ALU's `ena`, `opcode`, `data1` and `data2` inputs.

---
 rtl/alu_issuer_if.sv | 33 +++
 rtl/alu_issuer.sv | 116 +++++++++++
 tb/tb_alu_issuer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issuer_if.sv
// Bundles the command, ALU and response streams of alu_issuer.
// The issuer takes the slave side; the command source, consumer and ALU take the master side.
interface alu_issuer_if #(
   parameter int N = 8
);
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_opcode;
   logic [N-1:0] cmd_data1;
   logic [N-1:0] cmd_data2;
   logic         alu_ena;
   logic [1:0]   alu_opcode;
   logic [N-1:0] alu_data1;
   logic [N-1:0] alu_data2;
   logic [N:0]   alu_y;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [N:0]   rsp_y;
   logic [1:0]   rsp_opcode;
   logic         busy;

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_data1, cmd_data2, alu_y, rsp_ready,
      output cmd_ready, alu_ena, alu_opcode, alu_data1, alu_data2,
             rsp_valid, rsp_y, rsp_opcode, busy
   );

   modport master (
      output cmd_valid, cmd_opcode, cmd_data1, cmd_data2, alu_y, rsp_ready,
      input  cmd_ready, alu_ena, alu_opcode, alu_data1, alu_data2,
             rsp_valid, rsp_y, rsp_opcode, busy
   );
endinterface

// File: rtl/alu_issuer.sv
// Buffers ALU commands in a FIFO, issues them one at a time as a single-cycle
// enable pulse, and returns the captured ALU results in command order.
module alu_issuer #(
   parameter int N     = 8,
   parameter int DEPTH = 4
) (
   input logic         clk,
   input logic         rst_n,
   alu_issuer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = N + N + 2;
   localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [EW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          push_s, pop_s, empty_s, full_d, empty_d;
   logic          cmd_ready_q, alu_ena_q, rsp_valid_q, busy_q;
   logic [1:0]    alu_opcode_q, rsp_opcode_q;
   logic [N-1:0]  alu_data1_q, alu_data2_q;
   logic [N:0]    rsp_y_q;

   // Next-state, FIFO pointer and handshake decode.
   always_comb begin
      empty_s = (wr_ptr_q == rd_ptr_q);
      push_s  = bus.cmd_valid & cmd_ready_q;
      pop_s   = 1'b0;
      state_d = state_q;
      if (!empty_s) begin
         if (state_q == IDLE) begin
            pop_s = 1'b1;
         end else if ((state_q == RESP) && bus.rsp_ready) begin
            pop_s = 1'b1;
         end else begin
            pop_s = 1'b0;
         end
      end else begin
         pop_s = 1'b0;
      end
      case (state_q)
         IDLE:    state_d = pop_s ? ISSUE : IDLE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = pop_s ? ISSUE : IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_INC) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_INC) : rd_ptr_q;
      full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      empty_d  = (wr_ptr_d == rd_ptr_d);
   end

   // FSM, FIFO storage and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         cmd_ready_q  <= 1'b0;
         alu_ena_q    <= 1'b0;
         alu_opcode_q <= 2'b00;
         alu_data1_q  <= '0;
         alu_data2_q  <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_y_q      <= '0;
         rsp_opcode_q <= 2'b00;
         busy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cmd_ready_q <= !full_d;
         alu_ena_q   <= (state_d == ISSUE);
         busy_q      <= (state_d != IDLE) || !empty_d;
         if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {bus.cmd_opcode, bus.cmd_data1, bus.cmd_data2};
         end
         if (pop_s) begin
            {alu_opcode_q, alu_data1_q, alu_data2_q} <= mem_q[rd_ptr_q[AW-1:0]];
         end
         // alu_opcode_q still holds the issued opcode here; the next pop comes later.
         if (state_q == CAPTURE) begin
            rsp_y_q      <= bus.alu_y;
            rsp_opcode_q <= alu_opcode_q;
            rsp_valid_q  <= 1'b1;
         end else if ((state_q == RESP) && bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
         end
      end
   end

   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.alu_ena    = alu_ena_q;
   assign bus.alu_opcode = alu_opcode_q;
   assign bus.alu_data1  = alu_data1_q;
   assign bus.alu_data2  = alu_data2_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_y      = rsp_y_q;
   assign bus.rsp_opcode = rsp_opcode_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_alu_issuer.sv
// Scoreboard bench for alu_issuer with a behavioural 1-cycle registered ALU.
module tb_alu_issuer;
   localparam int N     = 8;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   int           cyc = 0;
   int           n_cmp = 0;
   int           n_fail = 0;
   bit           done;
   logic [N+2:0] exp_q [$];

   alu_issuer_if #(.N(N)) bus ();
   alu_issuer #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [N:0] ref_y(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N:0] r;
      case (op)
         2'b00: r = {a[N-1], a} + {b[N-1], b};
         2'b01: r = {a[N-1], a} - {b[N-1], b};
         2'b10: begin
            if ($signed(a) == $signed(b))     r = 9'd0;
            else if ($signed(a) > $signed(b)) r = 9'd1;
            else                              r = 9'd2;
         end
         default: r = 9'd0;
      endcase
      return r;
   endfunction

   // ALU: no reset, result registered one cycle after ena.
   always @(posedge clk) if (bus.alu_ena) bus.alu_y <= ref_y(bus.alu_opcode, bus.alu_data1, bus.alu_data2);

   task automatic send_cmd(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                           input int budget, output bit acc, output int t_acc);
      acc   = 1'b0;
      t_acc = 0;
      bus.cmd_valid = 1'b1; bus.cmd_opcode = op; bus.cmd_data1 = a; bus.cmd_data2 = b;
      for (int w = 0; w < budget; w++) begin
         if (bus.cmd_ready) begin
            @(posedge clk);
            acc = 1'b1;
            @(negedge clk);
            t_acc = cyc;
            break;
         end
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int budget, output bit seen);
      for (int w = 0; w < budget && !bus.rsp_valid; w++) @(negedge clk);
      seen = bus.rsp_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({bus.cmd_ready, bus.alu_ena, bus.rsp_valid, bus.busy} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {bus.cmd_ready, bus.alu_ena, bus.rsp_valid, bus.busy});
      end
      n_cmp++;
      if ({bus.alu_opcode, bus.alu_data1, bus.alu_data2} !== 18'd0) begin
         n_fail++; $display("FAIL reset_alu: got %h want 0", {bus.alu_opcode, bus.alu_data1, bus.alu_data2});
      end
      n_cmp++;
      if ({bus.rsp_opcode, bus.rsp_y} !== 11'd0) begin
         n_fail++; $display("FAIL reset_rsp: got %h want 0", {bus.rsp_opcode, bus.rsp_y});
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready);
      end
   endtask

   task automatic test_directed();
      logic [1:0]   ops [8];
      logic [N-1:0] as [8];
      logic [N-1:0] bs [8];
      logic [N:0]   ys [8];
      logic [N+2:0] e;
      bit           acc, seen;
      int           t_acc;
      ops = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11};
      as  = '{8'd100, 8'h7F, 8'h80, 8'd5, 8'd5, 8'd7, 8'hFD, 8'h55};
      bs  = '{8'd27, 8'h7F, 8'h7F, 8'hFD, 8'd5, 8'hFF, 8'd2, 8'h12};
      ys  = '{9'h07F, 9'h0FE, 9'h101, 9'h008, 9'h000, 9'h001, 9'h002, 9'h000};
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send_cmd(ops[i], as[i], bs[i], 10, acc, t_acc);
         n_cmp++;
         if (!acc) begin
            n_fail++; $display("FAIL dir_accept[%0d]: got not accepted want accepted", i);
         end else begin
            exp_q.push_back({ops[i], ys[i]});
            wait_rsp(10, seen);
            e = exp_q.pop_front();
            n_cmp++;
            if (!seen) begin
               n_fail++; $display("FAIL dir_timeout[%0d]: got no rsp_valid want rsp_valid", i);
            end else begin
               n_cmp++;
               if (cyc - t_acc != 3) begin
                  n_fail++; $display("FAIL dir_latency[%0d]: got %0d want 3", i, cyc - t_acc);
               end
               n_cmp++;
               if ({bus.rsp_opcode, bus.rsp_y} !== e) begin
                  n_fail++; $display("FAIL dir_result[%0d]: got op %b y %h want op %b y %h", i, bus.rsp_opcode, bus.rsp_y, e[N+2:N+1], e[N:0]);
               end
            end
            @(negedge clk);
            n_cmp++;
            if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
               n_fail++; $display("FAIL dir_idle[%0d]: got busy,valid %b want 00", i, {bus.busy, bus.rsp_valid});
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [1:0]   op;
      logic [N-1:0] a, b;
      logic [N:0]   y0;
      logic [N+2:0] e;
      bit           acc, seen;
      int           t_acc, n_acc, t_prev;
      bus.rsp_ready = 1'b0;
      n_acc = 0;
      t_prev = 0;
      for (int k = 0; k < 7; k++) begin
         op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
         send_cmd(op, a, b, 6, acc, t_acc);
         if (acc) begin
            n_acc++;
            exp_q.push_back({op, ref_y(op, a, b)});
         end
      end
      n_cmp++;
      if (n_acc != DEPTH + 1) begin
         n_fail++; $display("FAIL bp_accepted: got %0d want %0d", n_acc, DEPTH + 1);
      end
      n_cmp++;
      if (bus.cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_ready_low: got %b want 0", bus.cmd_ready);
      end
      wait_rsp(10, seen);
      y0 = bus.rsp_y;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (!seen || bus.rsp_valid !== 1'b1 || bus.rsp_y !== y0) begin
         n_fail++; $display("FAIL bp_stall_stable: got valid %b y %h want valid 1 y %h", bus.rsp_valid, bus.rsp_y, y0);
      end
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < n_acc; i++) begin
         wait_rsp(10, seen);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
         n_cmp++;
         if (!seen || {bus.rsp_opcode, bus.rsp_y} !== e) begin
            n_fail++; $display("FAIL bp_result[%0d]: got valid %b op %b y %h want op %b y %h", i, bus.rsp_valid, bus.rsp_opcode, bus.rsp_y, e[N+2:N+1], e[N:0]);
         end
         if (i > 0) begin
            n_cmp++;
            if (cyc - t_prev != 3) begin
               n_fail++; $display("FAIL bp_spacing[%0d]: got %0d want 3", i, cyc - t_prev);
            end
         end
         t_prev = cyc;
         if (i == 0) begin
            n_cmp++;
            if (bus.cmd_ready !== 1'b0) begin
               n_fail++; $display("FAIL bp_ready_before_pop: got %b want 0", bus.cmd_ready);
            end
         end
         @(negedge clk);
         if (i == 0) begin
            n_cmp++;
            if (bus.cmd_ready !== 1'b1) begin
               n_fail++; $display("FAIL bp_ready_release: got %b want 1", bus.cmd_ready);
            end
         end
      end
      n_cmp++;
      if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL bp_drain: got busy %b left %0d want busy 0 left 0", bus.busy, exp_q.size());
      end
   endtask

   task automatic test_stream();
      bus.rsp_ready = 1'b1;
      done = 1'b0;
      fork
         begin
            logic [1:0]   op;
            logic [N-1:0] a, b;
            bit           acc;
            int           t_acc;
            for (int k = 0; k < 8; k++) begin
               op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
               send_cmd(op, a, b, 12, acc, t_acc);
               n_cmp++;
               if (!acc) begin
                  n_fail++; $display("FAIL st_accept[%0d]: got not accepted want accepted", k);
               end else begin
                  exp_q.push_back({op, ref_y(op, a, b)});
               end
            end
         end
         begin
            logic [N+2:0] e;
            bit           seen;
            for (int k = 0; k < 8; k++) begin
               wait_rsp(20, seen);
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
               n_cmp++;
               if (!seen || {bus.rsp_opcode, bus.rsp_y} !== e) begin
                  n_fail++; $display("FAIL st_result[%0d]: got valid %b op %b y %h want op %b y %h", k, bus.rsp_valid, bus.rsp_opcode, bus.rsp_y, e[N+2:N+1], e[N:0]);
               end
               @(negedge clk);
            end
            done = 1'b1;
         end
         begin
            bit prev;
            int last, pulses;
            prev = 1'b0; last = -100; pulses = 0;
            for (int w = 0; w < 100 && !done; w++) begin
               @(negedge clk);
               if (prev) begin
                  n_cmp++;
                  if (bus.alu_ena) begin
                     n_fail++; $display("FAIL st_ena_width: got ena high 2 cycles want 1 cycle");
                  end
               end
               if (bus.alu_ena && !prev) begin
                  pulses++;
                  n_cmp++;
                  if (cyc - last < 3) begin
                     n_fail++; $display("FAIL st_ena_spacing: got %0d want >=3", cyc - last);
                  end
                  last = cyc;
               end
               prev = bus.alu_ena;
            end
            n_cmp++;
            if (pulses != 8) begin
               n_fail++; $display("FAIL st_ena_count: got %0d want 8", pulses);
            end
         end
      join
   endtask

   task automatic test_reset_midflight();
      logic [N+2:0] e;
      bit           acc0, acc1, acc2, seen, activity;
      int           t_acc;
      bus.rsp_ready = 1'b1;
      send_cmd(2'b00, 8'd1, 8'd2, 10, acc0, t_acc);
      send_cmd(2'b01, 8'd3, 8'd4, 10, acc1, t_acc);
      send_cmd(2'b10, 8'd5, 8'd6, 10, acc2, t_acc);
      n_cmp++;
      if (!(acc0 && acc1 && acc2) || {bus.busy, bus.alu_ena, bus.rsp_valid} !== 3'b100) begin
         n_fail++; $display("FAIL rm_setup: got acc %b%b%b busy,ena,valid %b want 111 100", acc0, acc1, acc2, {bus.busy, bus.alu_ena, bus.rsp_valid});
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.cmd_ready, bus.alu_ena, bus.rsp_valid, bus.busy, bus.alu_opcode, bus.alu_data1, bus.alu_data2, bus.rsp_opcode, bus.rsp_y} !== 33'd0) begin
         n_fail++; $display("FAIL rm_async_clear: got %h want 0", {bus.cmd_ready, bus.alu_ena, bus.rsp_valid, bus.busy, bus.alu_opcode, bus.alu_data1, bus.alu_data2, bus.rsp_opcode, bus.rsp_y});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      activity = 1'b0;
      for (int w = 0; w < 12; w++) begin
         @(negedge clk);
         if (bus.rsp_valid || bus.alu_ena || bus.busy) activity = 1'b1;
      end
      n_cmp++;
      if (activity) begin
         n_fail++; $display("FAIL rm_dropped: got activity after reset want none");
      end
      send_cmd(2'b00, 8'h10, 8'h20, 10, acc0, t_acc);
      exp_q.push_back({2'b00, 9'h030});
      wait_rsp(10, seen);
      e = exp_q.pop_front();
      n_cmp++;
      if (!acc0 || !seen || cyc - t_acc != 3 || {bus.rsp_opcode, bus.rsp_y} !== e) begin
         n_fail++; $display("FAIL rm_after: got valid %b lat %0d op %b y %h want lat 3 op %b y %h", bus.rsp_valid, cyc - t_acc, bus.rsp_opcode, bus.rsp_y, e[N+2:N+1], e[N:0]);
      end
      @(negedge clk);
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_opcode = 2'b00; bus.cmd_data1 = '0; bus.cmd_data2 = '0;
      bus.rsp_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_backpressure();
      test_stream();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
